key_seq_reader: RTL and testbench

- Bus-master sequencer that drives the read-sequence state machine in the key/security PAL at window BA13=0, BA12=1.
- Issues a fixed, parameterised series of strobed read cycles at window offsets selected by BA7..BA4, walking the PAL through its state sequence.
- Samples the two tristate response lines (SDRD and the auxiliary line) on each read and assembles them into a response word for the host.
- Requests the shared board bus through a req/gnt handshake and holds it across the whole sequence.

---
 rtl/key_seq_reader_if.sv | 20 ++
 rtl/key_seq_reader.sv | 148 ++++++++++++++
 tb/tb_key_seq_reader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_seq_reader_if.sv
// rtl/key_seq_reader_if.sv - board bus signals between the key sequencer and the security PAL
interface key_seq_reader_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [13:0] ba;
  logic        br_w;
  logic        sser;
  logic        sdrd;
  logic        aux_rd;

  modport master (
    output bus_req, ba, br_w, sser,
    input  bus_gnt, sdrd, aux_rd
  );

  modport slave (
    input  bus_req, ba, br_w, sser,
    output bus_gnt, sdrd, aux_rd
  );
endinterface

// File: rtl/key_seq_reader.sv
// rtl/key_seq_reader.sv - walks the key PAL read-state machine and collects its {aux,sdrd} replies
module key_seq_reader #(
  parameter int                   SEQ_LEN     = 8,
  parameter logic [4*SEQ_LEN-1:0] SEQ_NIBBLES = '0,
  parameter int                   STROBE_CYC  = 2,
  parameter int                   GNT_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [2*SEQ_LEN-1:0]   response,
  key_seq_reader_if.master       bus
);

  localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int SCNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam int WCNT_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STROBE_CYC - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(GNT_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]             state, state_n;
  logic [STEP_W-1:0]      step, step_n;
  logic [SCNT_W-1:0]      scnt, scnt_n;
  logic [WCNT_W-1:0]      wcnt, wcnt_n;
  logic                   timeout_n;
  logic [2*SEQ_LEN-1:0]   resp_n;
  logic [4*SEQ_LEN-1:0]   nib_shift;
  logic                   in_window;
  logic [13:0]            ba_n;
  logic                   bus_req_q;
  logic                   sser_q;
  logic [13:0]            ba_q;

  always_comb begin
    state_n   = state;
    step_n    = step;
    scnt_n    = scnt;
    wcnt_n    = wcnt;
    timeout_n = timeout;
    resp_n    = response;

    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            resp_n    = '0;
            timeout_n = 1'b0;
            step_n    = '0;
            wcnt_n    = '0;
            state_n   = S_REQ;
          end
        end
        S_REQ: begin
          if (bus.bus_gnt) begin
            state_n = S_SETUP;
          end else if (wcnt == WCNT_LAST) begin
            timeout_n = 1'b1;
            state_n   = S_IDLE;
          end else begin
            wcnt_n = wcnt + 1'b1;
          end
        end
        S_SETUP: begin
          // Grant is only checked here; once the strobe starts the read is finished regardless.
          if (bus.bus_gnt) begin
            scnt_n  = '0;
            state_n = S_STROBE;
          end else begin
            wcnt_n  = '0;
            state_n = S_REQ;
          end
        end
        S_STROBE: begin
          if (scnt == SCNT_LAST) begin
            resp_n[{step, 1'b0} +: 2] = {bus.aux_rd, bus.sdrd};
            state_n = S_RECOVER;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        S_RECOVER: begin
          if (step == STEP_LAST) begin
            state_n = S_DONE;
          end else begin
            step_n  = step + 1'b1;
            state_n = S_SETUP;
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end

    // Bus outputs are registered from the next state so they change cleanly on the edge.
    nib_shift = SEQ_NIBBLES >> {step_n, 2'b00};
    in_window = (state_n == S_SETUP) || (state_n == S_STROBE) || (state_n == S_RECOVER);
    ba_n      = in_window ? {2'b01, 4'b0000, nib_shift[3:0], 4'b0000} : 14'h0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= '0;
      scnt      <= '0;
      wcnt      <= '0;
      timeout   <= 1'b0;
      response  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bus_req_q <= 1'b0;
      sser_q    <= 1'b1;
      ba_q      <= 14'h0000;
    end else begin
      state     <= state_n;
      step      <= step_n;
      scnt      <= scnt_n;
      wcnt      <= wcnt_n;
      timeout   <= timeout_n;
      response  <= resp_n;
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
      bus_req_q <= in_window || (state_n == S_REQ);
      sser_q    <= (state_n != S_STROBE);
      ba_q      <= ba_n;
    end
  end

  assign bus.bus_req = bus_req_q;
  assign bus.sser    = sser_q;
  assign bus.ba      = ba_q;
  assign bus.br_w    = 1'b1;

endmodule

// File: tb/tb_key_seq_reader.sv
// tb/tb_key_seq_reader.sv - directed checks of key_seq_reader against a small PAL reply model
module tb_key_seq_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] response;
  logic        gnt;
  logic        pal_clr;
  logic [3:0]  pal_cnt;
  logic [3:0]  low_cnt;
  logic        sser_d;
  logic        pal_ok;
  logic        sdrd_v;
  logic        aux_v;

  int vectors;
  int miscompares;

  key_seq_reader_if bus_if ();

  key_seq_reader #(
    .SEQ_LEN     (8),
    .SEQ_NIBBLES (32'h8A8A_AA52),
    .STROBE_CYC  (2),
    .GNT_TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .response (response),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PAL model: reply depends on address and on how many reads it has seen; only valid late in the strobe.
  always @(posedge clk) begin
    sser_d  <= bus_if.sser;
    low_cnt <= bus_if.sser ? 4'd0 : low_cnt + 4'd1;
    if (pal_clr) pal_cnt <= 4'd0;
    else if (sser_d === 1'b0 && bus_if.sser === 1'b1) pal_cnt <= pal_cnt + 4'd1;
  end

  assign pal_ok         = (low_cnt != 4'd0);
  assign sdrd_v         = bus_if.ba[5] ^ pal_cnt[0];
  assign aux_v          = bus_if.ba[7] | pal_cnt[1];
  assign bus_if.bus_gnt = gnt;
  assign bus_if.sdrd    = pal_ok ? sdrd_v : ~sdrd_v;
  assign bus_if.aux_rd  = pal_ok ? aux_v : ~aux_v;

  function automatic logic [13:0] exp_ba(input int k);
    case (k)
      0:       return 14'h1020;
      1:       return 14'h1050;
      2:       return 14'h10A0;
      3:       return 14'h10A0;
      4:       return 14'h10A0;
      5:       return 14'h1080;
      6:       return 14'h10A0;
      7:       return 14'h1080;
      default: return 14'h0000;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; gnt = 1'b1; pal_clr = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, timeout, bus_if.bus_req, bus_if.sser, bus_if.br_w} !== 6'b000011) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 000011", {busy, done, timeout, bus_if.bus_req, bus_if.sser, bus_if.br_w});
    end
    vectors++;
    if (response !== 16'h0000 || bus_if.ba !== 14'h0000) begin
      miscompares++;
      $display("FAIL reset_data got resp=%h ba=%h want 0000/0000", response, bus_if.ba);
    end
    rst = 1'b0;
    @(negedge clk);
    pal_clr = 1'b0;
    vectors++;
    if (busy !== 1'b0 || bus_if.sser !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got busy=%b sser=%b want 0/1", busy, bus_if.sser);
    end
  endtask

  // Full sequence with grant high; optional start pulse while busy and optional grant drop in step 3 SETUP.
  task automatic run_seq(input string tag, input int restart_cyc, input bit drop);
    logic [13:0] eba, prev_ba;
    logic        esser, ereq, ebusy, edone;
    int          cc, k, ph, n;
    n = drop ? 41 : 38;
    pal_clr = 1'b1;
    @(negedge clk);
    pal_clr = 1'b0;
    gnt = 1'b1;
    start = 1'b1;
    prev_ba = bus_if.ba;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = 1'b0;
      cc = (drop && c >= 17) ? c - 3 : c;
      k  = (cc - 2) / 4;
      ph = (cc - 2) % 4;
      if (drop && (c == 15 || c == 16)) begin
        eba = 14'h0000; esser = 1'b1; ereq = 1'b1; ebusy = 1'b1; edone = 1'b0;
      end else begin
        eba   = (cc >= 2 && cc <= 33) ? exp_ba(k) : 14'h0000;
        esser = !(cc >= 2 && cc <= 33 && (ph == 1 || ph == 2));
        ereq  = (cc <= 33);
        ebusy = (cc <= 34);
        edone = (cc == 34);
      end
      vectors++;
      if (bus_if.ba !== eba) begin
        miscompares++;
        $display("FAIL %s_ba c=%0d got %h want %h", tag, c, bus_if.ba, eba);
      end
      vectors++;
      if (bus_if.sser !== esser) begin
        miscompares++;
        $display("FAIL %s_sser c=%0d got %b want %b", tag, c, bus_if.sser, esser);
      end
      vectors++;
      if (bus_if.bus_req !== ereq || busy !== ebusy) begin
        miscompares++;
        $display("FAIL %s_req_busy c=%0d got %b%b want %b%b", tag, c, bus_if.bus_req, busy, ereq, ebusy);
      end
      vectors++;
      if (done !== edone) begin
        miscompares++;
        $display("FAIL %s_done c=%0d got %b want %b", tag, c, done, edone);
      end
      vectors++;
      if ((bus_if.ba !== prev_ba && bus_if.sser !== 1'b1) || (bus_if.bus_req === 1'b0 && bus_if.sser !== 1'b1)) begin
        miscompares++;
        $display("FAIL %s_sser_guard c=%0d got sser=%b req=%b ba %h->%h want sser high", tag, c,
                 bus_if.sser, bus_if.bus_req, prev_ba, bus_if.ba);
      end
      if (drop && c == 16) begin
        vectors++;
        if (response[5:0] !== 6'h35) begin
          miscompares++;
          $display("FAIL %s_keep c=%0d got %h want 35", tag, c, response[5:0]);
        end
      end
      prev_ba = bus_if.ba;
      if (c == restart_cyc) start = 1'b1;
      if (drop && c == 14) gnt = 1'b0;
      if (drop && c == 16) gnt = 1'b1;
    end
    vectors++;
    if (response !== 16'hFFB5) begin
      miscompares++;
      $display("FAIL %s_response got %h want ffb5", tag, response);
    end
  endtask

  task automatic test_sequence();
    run_seq("seq", 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_seq("busy_start", 12, 1'b0);
  endtask

  task automatic test_grant_drop();
    run_seq("gnt_drop", 0, 1'b1);
  endtask

  task automatic test_timeout();
    gnt = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (bus_if.bus_req !== (c <= 4) || busy !== (c <= 4) || timeout !== (c >= 5) || done !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout c=%0d got req=%b busy=%b to=%b done=%b want %b%b%b0", c,
                 bus_if.bus_req, busy, timeout, done, c <= 4, c <= 4, c >= 5);
      end
    end
    gnt = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_clear got to=%b busy=%b want 0/1", timeout, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_abort got busy=%b to=%b want 0/0", busy, timeout);
    end
  endtask

  task automatic test_abort();
    pal_clr = 1'b1;
    @(negedge clk);
    pal_clr = 1'b0;
    gnt = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_done c=%0d got %b want 0", c, done);
      end
      if (c == 12) begin
        vectors++;
        if (bus_if.sser !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_in_strobe got sser=%b want 0", bus_if.sser);
        end
        abort = 1'b1;
      end
      if (c == 13) begin
        vectors++;
        if ({busy, bus_if.sser, bus_if.bus_req} !== 3'b010 || bus_if.ba !== 14'h0000) begin
          miscompares++;
          $display("FAIL abort_idle got busy/sser/req=%b ba=%h want 010/0000", {busy, bus_if.sser, bus_if.bus_req}, bus_if.ba);
        end
        vectors++;
        if (response !== 16'h0005) begin
          miscompares++;
          $display("FAIL abort_response got %h want 0005", response);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    pal_clr = 1'b1;
    @(negedge clk);
    pal_clr = 1'b0;
    gnt = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    vectors++;
    if (response !== 16'h0001 || bus_if.sser !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_pre got resp=%h sser=%b want 0001/0", response, bus_if.sser);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, bus_if.bus_req, bus_if.sser} !== 4'b0001 || response !== 16'h0000 || bus_if.ba !== 14'h0000) begin
      miscompares++;
      $display("FAIL arst_now got ctrl=%b resp=%h ba=%h want 0001/0000/0000",
               {busy, done, bus_if.bus_req, bus_if.sser}, response, bus_if.ba);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || bus_if.sser !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_after got busy=%b sser=%b want 0/1", busy, bus_if.sser);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if (busy !== 1'b0 || bus_if.bus_req !== 1'b0) begin
        miscompares++;
        $display("FAIL start_abort_idle c=%0d got busy=%b req=%b want 0/0", c, busy, bus_if.bus_req);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_sequence();
    test_start_while_busy();
    test_timeout();
    test_grant_drop();
    test_abort();
    test_async_reset();
    test_sequence();
    test_start_abort_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
